// File: rtl/timing_sequencer_if.sv
// Handshake bundle between the timing sequencer and the control-signal logic.
interface timing_sequencer_if #(
    parameter int CNT_W = 3,
    parameter int OP_W  = 3
);
    logic                    clr;
    logic                    hold;
    logic [OP_W-1:0]         ir_op;
    logic                    ir_i;
    logic [CNT_W-1:0]        count;
    logic [(1<<CNT_W)-1:0]   T;
    logic [(1<<OP_W)-1:0]    D;
    logic                    I;
    logic                    sc_err;

    modport master (
        output clr, hold, ir_op, ir_i,
        input  count, T, D, I, sc_err
    );

    modport slave (
        input  clr, hold, ir_op, ir_i,
        output count, T, D, I, sc_err
    );
endinterface

// File: rtl/timing_sequencer.sv
// Instruction-cycle sequence counter with T/D decode and T2 opcode latch.
// Optional sticky wrap watchdog: define TIMING_SEQ_WATCHDOG_EN.
module timing_sequencer #(
    parameter int CNT_W = 3,
    parameter int OP_W  = 3
) (
    input  logic               clk,
    input  logic               reset,
    timing_sequencer_if.slave  bus
);
    localparam int TW = 1 << CNT_W;
    localparam int DW = 1 << OP_W;
    localparam logic [CNT_W-1:0] LATCH_CNT = CNT_W'(2);
    localparam logic [CNT_W-1:0] LAST_CNT  = '1;

    logic [CNT_W-1:0] count;
    logic [OP_W-1:0]  op_reg;
    logic             i_reg;
    logic             d_valid;
    logic             advance;

    assign advance = !bus.clr && !bus.hold;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count   <= '0;
            op_reg  <= '0;
            i_reg   <= 1'b0;
            d_valid <= 1'b0;
        end else if (bus.clr) begin
            count   <= '0;
            d_valid <= 1'b0;
        end else if (!bus.hold) begin
            count <= count + CNT_W'(1);
            if (count == LATCH_CNT) begin
                op_reg  <= bus.ir_op;
                i_reg   <= bus.ir_i;
                d_valid <= 1'b1;
            end else if (count == LAST_CNT) begin
                // instruction ran off the end without clr: drop the decode
                d_valid <= 1'b0;
            end
        end
    end

`ifdef TIMING_SEQ_WATCHDOG_EN
    logic err_reg;
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            err_reg <= 1'b0;
        else if (advance && count == LAST_CNT)
            err_reg <= 1'b1;
    end
    assign bus.sc_err = err_reg;
`else
    logic unused_adv;
    assign unused_adv = advance;
    assign bus.sc_err = 1'b0;
`endif

    assign bus.count = count;
    assign bus.T     = {{(TW-1){1'b0}}, 1'b1} << count;
    assign bus.D     = d_valid ? ({{(DW-1){1'b0}}, 1'b1} << op_reg) : '0;
    assign bus.I     = i_reg;
endmodule

// File: tb/tb_timing_sequencer.sv
// Scoreboard bench: stimulus pushes model predictions, negedge monitor compares.
module tb_timing_sequencer;
    logic clk = 1'b0;
    logic reset;

    timing_sequencer_if #(.CNT_W(3), .OP_W(3)) bus ();

    timing_sequencer #(.CNT_W(3), .OP_W(3)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int cnt;
        int t;
        int d;
        int i;
        int err;
    } exp_t;

    exp_t q[$];
    int vectors = 0;
    int miscompares = 0;

    // reference state: instruction step number, latched opcode and flags
    int m_cnt, m_op, m_i, m_dv, m_err;

    function automatic exp_t predict();
        exp_t e;
        e.cnt = m_cnt;
        e.t   = 1 << m_cnt;
        e.d   = m_dv ? (1 << m_op) : 0;
        e.i   = m_i;
        e.err = m_err;
        return e;
    endfunction

    task automatic check(input exp_t e, input string tag);
        vectors++;
        if (int'(bus.count) != e.cnt || int'(bus.T) != e.t || int'(bus.D) != e.d ||
            int'(bus.I) != e.i || int'(bus.sc_err) != e.err) begin
            miscompares++;
            $display("FAIL %s: got count=%0d T=%02h D=%02h I=%0d err=%0d, want count=%0d T=%02h D=%02h I=%0d err=%0d",
                     tag, bus.count, bus.T, bus.D, bus.I, bus.sc_err,
                     e.cnt, e.t, e.d, e.i, e.err);
        end
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) check(q.pop_front(), "cycle");
    end

    task automatic model_reset();
        m_cnt = 0; m_op = 0; m_i = 0; m_dv = 0; m_err = 0;
    endtask

    // one clock edge under the given inputs; called at posedge+1
    task automatic step(input bit c, input bit h, input int op, input bit ii);
        bus.clr = c; bus.hold = h; bus.ir_op = op[2:0]; bus.ir_i = ii;
        @(posedge clk);
        if (c) begin
            m_cnt = 0; m_dv = 0;
        end else if (!h) begin
            if (m_cnt == 2) begin
                m_op = op; m_i = ii; m_dv = 1;
            end
            if (m_cnt == 7) begin
                m_cnt = 0; m_dv = 0;
`ifdef TIMING_SEQ_WATCHDOG_EN
                m_err = 1;
`endif
            end else m_cnt++;
        end
        #1;
        q.push_back(predict());
    endtask

    // asynchronous reset mid-cycle, checked before the next edge
    task automatic do_reset();
        reset = 1'b1;
        model_reset();
        q.delete();
        #1;
        check(predict(), "async_reset");
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic run_to(input int k, input int op);
        for (int n = 0; n < 8 && m_cnt != k; n++) step(0, 0, op, 0);
    endtask

    initial begin
        reset = 1'b1;
        bus.clr = 0; bus.hold = 0; bus.ir_op = '0; bus.ir_i = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check(predict(), "reset_state");
        reset = 1'b0;

        // free run through a full wrap
        repeat (9) step(0, 0, 0, 0);
        step(1, 0, 0, 0);

        // opcode latch, late opcode change, clr at T5
        run_to(2, 0);
        step(0, 0, 5, 1);
        step(0, 0, 2, 0);
        step(0, 0, 2, 0);
        run_to(5, 1);
        step(1, 0, 3, 0);

        // hold three cycles during T4, then clr+hold at T4
        run_to(4, 0);
        repeat (3) step(0, 1, 0, 0);
        step(0, 0, 0, 0);
        step(1, 0, 0, 0);
        run_to(4, 0);
        step(1, 1, 0, 0);

        // clr at T2 must suppress the latch
        run_to(2, 0);
        step(1, 0, 7, 0);
        run_to(4, 0);

        // wrap watchdog, sticky across clr pulses
        do_reset();
        repeat (8) step(0, 0, 1, 0);
        step(1, 0, 0, 0);
        step(0, 0, 0, 0);
        step(1, 0, 0, 0);

        // async reset at T6 with D=08
        run_to(2, 0);
        step(0, 0, 3, 1);
        run_to(6, 0);
        do_reset();
        repeat (3) step(0, 0, 0, 0);

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 249) == 0) do_reset();
            step($urandom_range(0, 7) == 0, $urandom_range(0, 4) == 0,
                 int'($urandom_range(0, 7)), $urandom_range(0, 1) == 1);
        end

        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/timing_sequencer.md
# timing_sequencer

Instruction-cycle timing sequencer for the basic computer control unit. It owns the 3-bit sequence counter and decodes it into one-hot timing signals T[7:0]. It latches the instruction opcode and indirect bit at T2 and decodes the opcode into one-hot D[7:0]. These T/D/I outputs feed the control-signal logic, which in turn returns the synchronous `clr` that ends each instruction, so this block is the consumer end of that clear path.

## Interface
Parameters:
- CNT_W, default 3: sequence counter width; T width is 2**CNT_W.
- OP_W, default 3: opcode width; D width is 2**OP_W.

Ports:
- clk, in, 1: single clock; all state updates on the rising edge.
- reset, in, 1: asynchronous, active-high reset.
- clr, in, 1: synchronous counter clear from control-signal logic; end of instruction.
- hold, in, 1: stall; freezes the counter, e.g. memory not ready.
- ir_op, in, OP_W: opcode field (IR[14:12]), sampled at T2.
- ir_i, in, 1: indirect bit (IR[15]), sampled at T2.
- count, out, CNT_W: current sequence count.
- T, out, 2**CNT_W: one-hot decode of count.
- D, out, 2**OP_W: one-hot decode of the latched opcode; all zero when not valid.
- I, out, 1: latched indirect bit.
- sc_err, out, 1: sticky sequencing error (see Configuration).

## Operation
- State registers: count, op_reg, i_reg, d_valid, err_reg.
- Reset values: count=0, T=8'h01, op_reg=0, i_reg=0, d_valid=0, D=8'h00, I=0, sc_err=0.
- Per-edge priority is reset > clr > hold > increment.
  - clr=1: count←0 and d_valid←0, regardless of hold.
  - hold=1 (clr=0): all registers hold.
  - Otherwise: count←count+1, modulo 2**CNT_W.
- Opcode latch: on an edge where count==2, hold=0 and clr=0, op_reg←ir_op, i_reg←ir_i and d_valid←1.
  - If clr is asserted at T2, the latch is suppressed.
- D = d_valid ? (1 << op_reg) : 0, so D is valid from T3 until clr.
- I = i_reg. It is not cleared by clr and holds until the next T2 latch.
- Wrap-around: increment from count==2**CNT_W-1 with clr=0 sets count←0 and d_valid←0. This also sets err_reg when the watchdog is compiled in.
- Reset asserted mid-instruction immediately forces all reset values, without waiting for a clock edge. Counting resumes from T0 on the first edge after reset deasserts.
- hold and clr together: clr wins; count goes to 0 with no stall.

## Timing
- T and D are combinational decodes of registered state; there is no extra latency.
- T changes one cycle after each non-held edge.
- T is exactly one-hot at all times after reset.
- D becomes non-zero in the cycle after the T2 edge, i.e. the first cycle of T3.
- clr sampled at edge n gives T0 and D=0 in cycle n+1.
- Each cycle with hold=1 extends the current T state by exactly one cycle.
- Minimum instruction length is 1 cycle (clr held continuously keeps T0). Maximum is 2**CNT_W cycles before wrap.

## Configuration
- Macro: TIMING_SEQ_WATCHDOG_EN.
- Defined:
  - err_reg sets on any wrap-around increment, i.e. an instruction reached T7 and advanced without clr.
  - sc_err=err_reg is sticky; only reset clears it.
  - clr does not clear it.
- Undefined:
  - err_reg is not implemented and sc_err is tied to 0.
  - Wrap-around still zeroes count and d_valid silently.

## Test plan
- Reset then free-run: release reset with clr=hold=0. T must go 01,02,04,...,80,01 on successive cycles. D stays 00 until cycle T3.
- Opcode latch: ir_op=3'd5, ir_i=1 at T2. Expect D=8'h20 and I=1 from T3. Changing ir_op at T4 must leave D unchanged. Asserting clr at T5 gives T=01 and D=00 next cycle, with I still 1.
- Hold: assert hold for 3 cycles during T4. T=10 must persist for 4 cycles total, then T=20. With clr and hold both high at T4, the next cycle must be T=01.
- Clear at T2: clr=1 when count==2 with ir_op=3'd7. The next cycle gives T=01 and D=00, and op_reg is not updated.
- Wrap/watchdog: run 8 increments from T0 with no clr.
  - Defined: count=0, D=00 and sc_err=1; sc_err stays 1 through later clr pulses and clears only on reset.
  - Undefined: sc_err stays 0.
- Async reset: assert reset mid-cycle at T6 with D=8'h08. count, T, D and I must take reset values before the next clk edge.
